// File: rtl/iomem_gpio_pkg.sv
`default_nettype none
// ==================================================================
// gpio_pkg : register map, bus FSM encoding and strobe helper
// Rev 1.0
// ==================================================================
package gpio_pkg;

  localparam int MAX_PINS = 32;

  localparam logic [7:0] OFF_DATA_OUT    = 8'h00;
  localparam logic [7:0] OFF_OE          = 8'h04;
  localparam logic [7:0] OFF_DATA_IN     = 8'h08;
  localparam logic [7:0] OFF_EDGE_RISE   = 8'h0C;
  localparam logic [7:0] OFF_EDGE_FALL   = 8'h10;
  localparam logic [7:0] OFF_EDGE_STATUS = 8'h14;
  localparam logic [7:0] OFF_IRQ_MASK    = 8'h18;
  localparam logic [7:0] OFF_SET_OUT     = 8'h1C;
  localparam logic [7:0] OFF_CLR_OUT     = 8'h20;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [MAX_PINS-1:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iomem_gpio_sync_edge.sv
`default_nettype none
// ==================================================================
// gpio_sync_edge : multi-flop input synchroniser plus edge detect
// Rev 1.0
// ==================================================================
module gpio_sync_edge #(
  parameter int WIDTH  = 25,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule
`default_nettype wire

// File: rtl/iomem_gpio.sv
`default_nettype none
// ==================================================================
// iomem_gpio : GPIO pin bank on the iomem bus with edge-capture IRQ
// Rev 1.0
// ==================================================================
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int          NUM_PINS    = 25,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  input  logic [3:0]          iomem_wstrb,
  output logic [31:0]         iomem_rdata,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic [NUM_PINS-1:0] gpio_do,
  input  logic [NUM_PINS-1:0] gpio_di,
  output logic                irq
);

  bus_state_e          state_q;
  logic                ready_q;
  logic [31:0]         rdata_q;

  logic [NUM_PINS-1:0] dout_q, dout_d;
  logic [NUM_PINS-1:0] oe_q, oe_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic [NUM_PINS-1:0] mask_q, mask_d;

  logic [NUM_PINS-1:0] pin_sync, pin_rise, pin_fall;
  logic [NUM_PINS-1:0] wmask, wbits, edge_set, w1c_clr;
  logic [MAX_PINS-1:0] wmask_full, wbits_full, rd_word;
  logic [7:0]          offset;
  logic                hit, accept, wr_en;
  logic                unused_bits;

  gpio_sync_edge #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .din_i  (gpio_di),
    .sync_o (pin_sync),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  assign offset     = iomem_addr[7:0];
  assign hit        = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept     = (state_q == ST_IDLE) && iomem_valid && hit && !ready_q;
  assign wr_en      = accept && (iomem_wstrb != 4'b0000);
  assign wmask_full = strb_to_mask(iomem_wstrb);
  assign wbits_full = iomem_wdata & wmask_full;
  assign wmask      = wmask_full[NUM_PINS-1:0];
  assign wbits      = wbits_full[NUM_PINS-1:0];
  // Bits above NUM_PINS are intentionally ignored on writes.
  assign unused_bits = ^{wmask_full, wbits_full};

  always_comb begin
    dout_d    = dout_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    w1c_clr   = '0;
    edge_set  = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
    if (wr_en) begin
      case (offset)
        OFF_DATA_OUT:    dout_d    = (dout_q & ~wmask) | wbits;
        OFF_OE:          oe_d      = (oe_q & ~wmask) | wbits;
        OFF_EDGE_RISE:   rise_en_d = (rise_en_q & ~wmask) | wbits;
        OFF_EDGE_FALL:   fall_en_d = (fall_en_q & ~wmask) | wbits;
        OFF_EDGE_STATUS: w1c_clr   = wbits;
        OFF_IRQ_MASK:    mask_d    = (mask_q & ~wmask) | wbits;
        OFF_SET_OUT:     dout_d    = dout_q | wbits;
        OFF_CLR_OUT:     dout_d    = dout_q & ~wbits;
        default:         ;
      endcase
    end
    // A new edge on the same cycle as its clear must survive.
    status_d = (status_q & ~w1c_clr) | edge_set;
  end

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_DATA_OUT:    rd_word[NUM_PINS-1:0] = dout_q;
      OFF_OE:          rd_word[NUM_PINS-1:0] = oe_q;
      OFF_DATA_IN:     rd_word[NUM_PINS-1:0] = pin_sync;
      OFF_EDGE_RISE:   rd_word[NUM_PINS-1:0] = rise_en_q;
      OFF_EDGE_FALL:   rd_word[NUM_PINS-1:0] = fall_en_q;
      OFF_EDGE_STATUS: rd_word[NUM_PINS-1:0] = status_q;
      OFF_IRQ_MASK:    rd_word[NUM_PINS-1:0] = mask_q;
      default:         ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ACK;
            ready_q <= 1'b1;
            rdata_q <= (iomem_wstrb == 4'b0000) ? rd_word : '0;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      mask_q    <= '0;
    end else begin
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_oe     = oe_q;
  assign gpio_do     = dout_q;
  assign irq         = |(status_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ==================================================================
// tb_iomem_gpio : table-driven bench with read-data scoreboard
// Rev 1.0
// ==================================================================
module tb_iomem_gpio;
  import gpio_pkg::*;

  localparam int          NP   = 25;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [31:0]   iomem_addr = '0;
  logic [31:0]   iomem_wdata = '0;
  logic [3:0]    iomem_wstrb = '0;
  logic [31:0]   iomem_rdata;
  logic [NP-1:0] gpio_oe, gpio_do;
  logic [NP-1:0] gpio_di = '0;
  logic          irq;

  iomem_gpio #(
    .NUM_PINS    (NP),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .iomem_rdata (iomem_rdata),
    .gpio_oe     (gpio_oe),
    .gpio_do     (gpio_do),
    .gpio_di     (gpio_di),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_do;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete bus access; returns irq as seen in the ready cycle.
  task automatic access(input string name, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] exp_rd, output logic irq_rdy);
    int          lat = 0;
    logic [31:0] exp;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    if (strb == 4'b0000) sb_q.push_back(exp_rd);
    do begin
      @(negedge clk);
      lat++;
    end while (!iomem_ready && lat < 8);
    irq_rdy = irq;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    check({name, " ready latency"}, lat, 1);
    if (strb == 4'b0000) begin
      exp = sb_q.pop_front();
      if (iomem_ready) check({name, " rdata"}, iomem_rdata, exp);
    end
    @(negedge clk);
    check({name, " ready drop"}, {31'b0, iomem_ready}, 0);
    check({name, " rdata idle"}, iomem_rdata, 0);
  endtask

  task automatic access_miss(input string name, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wd);
    int seen = 0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    repeat (4) begin
      @(negedge clk);
      if (iomem_ready) seen++;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    check({name, " no ready"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir;
    logic seen;
    tbl[0]  = '{OFF_OE,          4'hF,    32'h01FF_FFFF, 32'h0, 32'h0000_0000};
    tbl[1]  = '{OFF_DATA_OUT,    4'b0011, 32'h00A5_A5A5, 32'h0, 32'h0000_A5A5};
    tbl[2]  = '{OFF_DATA_OUT,    4'h0,    32'h0,         32'h0000_A5A5, 32'h0000_A5A5};
    tbl[3]  = '{OFF_SET_OUT,     4'hF,    32'h0000_0010, 32'h0, 32'h0000_A5B5};
    tbl[4]  = '{OFF_CLR_OUT,     4'hF,    32'h0000_0001, 32'h0, 32'h0000_A5B4};
    tbl[5]  = '{OFF_DATA_OUT,    4'h0,    32'h0,         32'h0000_A5B4, 32'h0000_A5B4};
    tbl[6]  = '{OFF_DATA_IN,     4'h0,    32'h0,         32'h0000_0000, 32'h0000_A5B4};
    tbl[7]  = '{OFF_OE,          4'hF,    32'hFFFF_FFFF, 32'h0, 32'h0000_A5B4};
    tbl[8]  = '{OFF_OE,          4'h0,    32'h0,         32'h01FF_FFFF, 32'h0000_A5B4};
    tbl[9]  = '{8'h3C,           4'hF,    32'hFFFF_FFFF, 32'h0, 32'h0000_A5B4};
    tbl[10] = '{8'h3C,           4'h0,    32'h0,         32'h0000_0000, 32'h0000_A5B4};
    tbl[11] = '{OFF_DATA_OUT,    4'b0100, 32'h1234_5678, 32'h0, 32'h0034_A5B4};
    tbl[12] = '{OFF_CLR_OUT,     4'b0001, 32'hFFFF_FFFF, 32'h0, 32'h0034_A500};
    tbl[13] = '{OFF_DATA_OUT,    4'h0,    32'h0,         32'h0034_A500, 32'h0034_A500};
    tbl[14] = '{OFF_SET_OUT,     4'h0,    32'h0,         32'h0000_0000, 32'h0034_A500};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset gpio_oe", 32'(gpio_oe), 0);
    check("reset gpio_do", 32'(gpio_do), 0);
    check("reset irq", {31'b0, irq}, 0);
    check("reset rdata", iomem_rdata, 0);
    check("reset ready", {31'b0, iomem_ready}, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      access($sformatf("vec%0d", i), BASE + 32'(tbl[i].off), tbl[i].strb, tbl[i].wd,
             tbl[i].exp_rd, ir);
      check($sformatf("vec%0d gpio_do", i), 32'(gpio_do), tbl[i].exp_do);
    end
    check("gpio_oe after table", 32'(gpio_oe), 32'h01FF_FFFF);

    // Pad value reads back even with output drivers disabled.
    access("oe off", BASE + OFF_OE, 4'hF, 32'h0, 32'h0, ir);
    @(negedge clk);
    gpio_di = 25'h3;
    repeat (3) @(negedge clk);
    access("data_in 3", BASE + OFF_DATA_IN, 4'h0, 32'h0, 32'h3, ir);

    access("rise en", BASE + OFF_EDGE_RISE, 4'hF, 32'h4, 32'h0, ir);
    access("irq mask", BASE + OFF_IRQ_MASK, 4'hF, 32'h4, 32'h0, ir);
    check("irq before edge", {31'b0, irq}, 0);
    @(negedge clk);
    gpio_di = 25'h7;
    seen = 1'b0;
    for (int k = 0; k < SS + 1 && !seen; k++) begin
      @(negedge clk);
      seen = irq;
    end
    check("irq on rise", {31'b0, seen}, 1);
    access("status after rise", BASE + OFF_EDGE_STATUS, 4'h0, 32'h0, 32'h4, ir);
    access("w1c bit2", BASE + OFF_EDGE_STATUS, 4'hF, 32'h4, 32'h0, ir);
    check("irq after w1c", {31'b0, ir}, 0);

    // Fall on pin 2 with falling edges disabled, then rise timed onto the w1c commit.
    @(negedge clk);
    gpio_di = 25'h3;
    repeat (SS + 2) @(negedge clk);
    check("irq no fall", {31'b0, irq}, 0);
    @(negedge clk);
    gpio_di = 25'h7;
    repeat (SS - 1) @(negedge clk);
    access("w1c vs rise", BASE + OFF_EDGE_STATUS, 4'hF, 32'h4, 32'h0, ir);
    check("irq set wins", {31'b0, ir}, 1);
    access("status set wins", BASE + OFF_EDGE_STATUS, 4'h0, 32'h0, 32'h4, ir);
    access("w1c again", BASE + OFF_EDGE_STATUS, 4'hF, 32'h4, 32'h0, ir);
    check("irq cleared", {31'b0, ir}, 0);

    access("fall en", BASE + OFF_EDGE_FALL, 4'hF, 32'h1, 32'h0, ir);
    @(negedge clk);
    gpio_di = 25'h6;
    repeat (SS + 2) @(negedge clk);
    check("irq masked fall", {31'b0, irq}, 0);
    access("status fall", BASE + OFF_EDGE_STATUS, 4'h0, 32'h0, 32'h1, ir);
    access("mask 5", BASE + OFF_IRQ_MASK, 4'hF, 32'h5, 32'h0, ir);
    check("irq unmasked fall", {31'b0, ir}, 1);

    access_miss("miss read", BASE + 32'h100, 4'h0, 32'h0);
    access_miss("miss write", BASE + 32'h100, 4'hF, 32'h0000_FFFF);
    access("dout after miss", BASE + OFF_DATA_OUT, 4'h0, 32'h0, 32'h0034_A500, ir);

    // Back-to-back reads with valid held: ready, gap, ready.
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + OFF_DATA_IN;
    iomem_wstrb = 4'h0;
    sb_q.push_back(32'h6);
    sb_q.push_back(32'h6);
    @(negedge clk);
    check("b2b ready 1", {31'b0, iomem_ready}, 1);
    check("b2b rdata 1", iomem_rdata, sb_q.pop_front());
    @(negedge clk);
    check("b2b gap", {31'b0, iomem_ready}, 0);
    @(negedge clk);
    check("b2b ready 2", {31'b0, iomem_ready}, 1);
    check("b2b rdata 2", iomem_rdata, sb_q.pop_front());
    iomem_valid = 1'b0;
    @(negedge clk);
    check("b2b drop", {31'b0, iomem_ready}, 0);

    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + OFF_DATA_OUT;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h00FF_FFFF;
    rst = 1'b1;
    @(negedge clk);
    check("rst mid ready", {31'b0, iomem_ready}, 0);
    rst = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check("rst mid gpio_do", 32'(gpio_do), 0);
    check("rst mid irq", {31'b0, irq}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
